// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Byte-stream program loader and instruction fetch for the
//               sorting core. Packs bytes little-endian into 32-bit words,
//               holds the core in reset until the last byte arrives, then
//               serves combinational fetches from the core's PC.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [31:0]       pc,
    output logic [31:0]       ins,
    output logic              core_rst,
    output logic              loaded,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [31:0]     c_nop   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_lane;
    logic [31:0]       r_asm;
    logic [ADDR_W:0]   r_word_count;
    logic              r_core_rst;
    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_full;
    logic              w_word_done;
    logic              w_write;
    logic [4:0]        w_shift;
    logic [31:0]       w_word;
    logic [ADDR_W-1:0] w_idx;
    logic              w_in_range;

    // Handshake and word-assembly decode; the incoming byte is merged into
    // the assembly register so a word can be written on the byte that ends it.
    always_comb begin
        w_accept    = in_valid && in_ready;
        w_full      = (r_word_count == c_depth);
        w_word_done = (r_lane == 2'd3) || in_last;
        w_write     = w_accept && !w_full && w_word_done;
        w_shift     = {r_lane, 3'b000};
        w_word      = r_asm | (32'(in_data) << w_shift);
    end

    // State register; reset always returns to LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: overflow takes priority over in_last; RUN and ERR are sticky.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_accept) begin
                    if (w_full) begin
                        w_state_nxt = S_ERR;
                    end else if (in_last) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN:   w_state_nxt = S_RUN;
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Core reset is registered so it falls in the same cycle loaded rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_rst <= 1'b1;
        end else begin
            r_core_rst <= (w_state_nxt != S_RUN);
        end
    end

    // Lane counter, assembly register and word counter; dropped bytes on
    // overflow leave all three untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane       <= 2'd0;
            r_asm        <= 32'd0;
            r_word_count <= '0;
        end else if (w_accept && !w_full) begin
            if (w_word_done) begin
                r_lane       <= 2'd0;
                r_asm        <= 32'd0;
                r_word_count <= r_word_count + 1'b1;
            end else begin
                r_lane       <= r_lane + 2'd1;
                r_asm        <= w_word;
            end
        end
    end

    // Instruction memory write port; contents survive reset and are masked
    // by word_count instead.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_word_count[ADDR_W-1:0]] <= w_word;
        end
    end

    // Combinational fetch: out-of-range or not-yet-written addresses read NOP.
    always_comb begin
        w_idx      = pc[ADDR_W+1:2];
        w_in_range = (pc[31:ADDR_W+2] == '0) && ({1'b0, w_idx} < r_word_count);
        ins        = w_in_range ? r_mem[w_idx] : c_nop;
    end

    assign in_ready   = (r_state == S_LOAD);
    assign loaded     = (r_state == S_RUN);
    assign err        = (r_state == S_ERR);
    assign core_rst   = r_core_rst;
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard bench for imem_loader. Two instances (DEPTH=256
//               and DEPTH=4) share one byte stream; stimulus queues expected
//               values and a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int K_INS   = 0;
    localparam int K_WC    = 1;
    localparam int K_CRST  = 2;
    localparam int K_LOAD  = 3;
    localparam int K_ERR   = 4;
    localparam int K_READY = 5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic [31:0] pc = 32'd0;

    logic        a_ready, a_crst, a_loaded, a_err;
    logic [31:0] a_ins;
    logic [8:0]  a_wc;
    logic        b_ready, b_crst, b_loaded, b_err;
    logic [31:0] b_ins;
    logic [2:0]  b_wc;

    int n_checks = 0;
    int n_errors = 0;

    int          q_kind [$];
    int          q_sel  [$];
    logic [31:0] q_exp  [$];
    string       q_name [$];

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(a_ready), .pc(pc), .ins(a_ins),
        .core_rst(a_crst), .loaded(a_loaded), .err(a_err), .word_count(a_wc)
    );

    imem_loader #(.DEPTH(4), .ADDR_W(2)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(b_ready), .pc(pc), .ins(b_ins),
        .core_rst(b_crst), .loaded(b_loaded), .err(b_err), .word_count(b_wc)
    );

    function automatic logic [31:0] actual(input int kind, input int sel);
        logic [31:0] v;
        v = 32'hDEAD_BEEF;
        case (kind)
            K_INS:   v = (sel == 0) ? a_ins : b_ins;
            K_WC:    v = (sel == 0) ? 32'(a_wc) : 32'(b_wc);
            K_CRST:  v = (sel == 0) ? 32'(a_crst) : 32'(b_crst);
            K_LOAD:  v = (sel == 0) ? 32'(a_loaded) : 32'(b_loaded);
            K_ERR:   v = (sel == 0) ? 32'(a_err) : 32'(b_err);
            K_READY: v = (sel == 0) ? 32'(a_ready) : 32'(b_ready);
            default: v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    // Monitor: compare every queued expectation at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (q_kind.size() > 0) begin
                int          k, s;
                logic [31:0] e, a;
                string       nm;
                k  = q_kind.pop_front();
                s  = q_sel.pop_front();
                e  = q_exp.pop_front();
                nm = q_name.pop_front();
                a  = actual(k, s);
                n_checks++;
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL %s (dut%0d): got %h expected %h", nm, s, a, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_v(input int kind, input int sel, input logic [31:0] e, input string nm);
        q_kind.push_back(kind);
        q_sel.push_back(sel);
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic flush();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_ins(input int sel, input logic [31:0] p, input logic [31:0] e, input string nm);
        pc = p;
        expect_v(K_INS, sel, e, nm);
        flush();
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] prog1 [8] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00};
    logic [7:0] prog2 [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};

    initial begin
        // Reset state
        do_reset();
        expect_v(K_WC,    0, 32'd0, "rst_word_count");
        expect_v(K_CRST,  0, 32'd1, "rst_core_rst");
        expect_v(K_READY, 0, 32'd1, "rst_in_ready");
        expect_v(K_LOAD,  0, 32'd0, "rst_loaded");
        expect_v(K_ERR,   0, 32'd0, "rst_err");
        chk_ins(0, 32'h0, NOP, "rst_ins_pc0");

        // Load and release
        for (int i = 0; i < 7; i++) send(prog1[i], 1'b0);
        expect_v(K_CRST, 0, 32'd1, "pre_last_core_rst");
        expect_v(K_WC,   0, 32'd1, "pre_last_word_count");
        flush();
        send(prog1[7], 1'b1);
        expect_v(K_CRST,  0, 32'd0, "release_core_rst");
        expect_v(K_LOAD,  0, 32'd1, "release_loaded");
        expect_v(K_READY, 0, 32'd0, "release_in_ready");
        expect_v(K_WC,    0, 32'd2, "load_word_count");
        flush();
        chk_ins(0, 32'h0, 32'h0050_0513, "load_ins_pc0");
        chk_ins(0, 32'h4, 32'h0060_0593, "load_ins_pc4");
        chk_ins(0, 32'h8, NOP,           "load_ins_pc8");

        // Partial final word
        do_reset();
        for (int i = 0; i < 6; i++) send(prog2[i], i == 5);
        expect_v(K_WC,   0, 32'd2, "partial_word_count");
        expect_v(K_LOAD, 0, 32'd1, "partial_loaded");
        flush();
        chk_ins(0, 32'h0, 32'hDDCC_BBAA, "partial_ins_pc0");
        chk_ins(0, 32'h6, 32'h0000_2211, "partial_ins_pc6");

        // Stalls between bytes 2 and 3, then bytes offered in RUN
        do_reset();
        send(8'h13, 1'b0);
        send(8'h05, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        send(8'h50, 1'b0);
        send(8'h00, 1'b1);
        expect_v(K_WC, 0, 32'd1, "stall_word_count");
        flush();
        chk_ins(0, 32'h0, 32'h0050_0513, "stall_ins_pc0");
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_v(K_WC,    0, 32'd1, "run_ignore_word_count");
        expect_v(K_READY, 0, 32'd0, "run_in_ready");
        flush();
        chk_ins(0, 32'h0, 32'h0050_0513, "run_ignore_ins_pc0");
        chk_ins(0, 32'h4, NOP,           "run_ignore_ins_pc4");

        // Overflow on the DEPTH=4 instance
        do_reset();
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        expect_v(K_WC,    1, 32'd4, "full_word_count");
        expect_v(K_ERR,   1, 32'd0, "full_err");
        expect_v(K_READY, 1, 32'd1, "full_in_ready");
        flush();
        send(8'd16, 1'b0);
        expect_v(K_ERR,   1, 32'd1, "ovf_err");
        expect_v(K_WC,    1, 32'd4, "ovf_word_count");
        expect_v(K_CRST,  1, 32'd1, "ovf_core_rst");
        expect_v(K_READY, 1, 32'd0, "ovf_in_ready");
        expect_v(K_LOAD,  1, 32'd0, "ovf_loaded");
        expect_v(K_ERR,   0, 32'd0, "big_no_err");
        expect_v(K_WC,    0, 32'd4, "big_word_count");
        expect_v(K_READY, 0, 32'd1, "big_in_ready");
        flush();
        chk_ins(1, 32'h0,  32'h0302_0100, "ovf_ins_pc0");
        chk_ins(1, 32'hC,  32'h0F0E_0D0C, "ovf_ins_pc12");
        chk_ins(1, 32'h10, NOP,           "ovf_ins_pc16");
        chk_ins(0, 32'h10, NOP,           "big_ins_pc16");
        send(8'hEE, 1'b1);
        expect_v(K_ERR,  1, 32'd1, "err_sticky");
        expect_v(K_CRST, 1, 32'd1, "err_core_rst_sticky");
        flush();

        // Exact fit on the DEPTH=4 instance
        do_reset();
        expect_v(K_ERR, 1, 32'd0, "rst_from_err");
        flush();
        for (int i = 0; i < 16; i++) send(8'(i + 4), i == 15);
        expect_v(K_LOAD, 1, 32'd1, "fit_loaded");
        expect_v(K_ERR,  1, 32'd0, "fit_err");
        expect_v(K_WC,   1, 32'd4, "fit_word_count");
        expect_v(K_CRST, 1, 32'd0, "fit_core_rst");
        flush();
        chk_ins(1, 32'hC, 32'h1312_1110, "fit_ins_pc12");

        // Reset mid-load, then reload a one-word program
        do_reset();
        for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), 1'b0);
        do_reset();
        expect_v(K_WC,   0, 32'd0, "midrst_word_count");
        expect_v(K_CRST, 0, 32'd1, "midrst_core_rst");
        flush();
        send(8'h63, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b1);
        expect_v(K_WC,   0, 32'd1, "reload_word_count");
        expect_v(K_LOAD, 0, 32'd1, "reload_loaded");
        flush();
        chk_ins(0, 32'h0,    32'h0000_0063, "reload_ins_pc0");
        chk_ins(0, 32'h4,    NOP,           "reload_ins_pc4_stale");
        chk_ins(0, 32'h1000, NOP,           "reload_ins_out_of_range");
        chk_ins(1, 32'h4,    NOP,           "small_ins_pc4_stale");

        flush();
        if (q_kind.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_kind.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
